// File: rtl/dm_bus.sv
// Byte-addressed data memory for the MEM stage: byte/half/word stores via lane merge,
// extended loads, alignment/range exception flags and a request/ready handshake with wait states.
module dm_bus #(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned AW          = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        exc_adel,
  output logic        exc_ades
);

  localparam int unsigned CW = 4;
  localparam logic [32:0] BYTE_LIMIT = 33'(4 * DEPTH_WORDS);
  localparam logic [CW-1:0] WAIT_LOAD = CW'((WAIT_CYCLES == 0) ? 0 : (WAIT_CYCLES - 1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [31:0]   r_rdata;
  logic          r_ready;
  logic          r_busy;
  logic          r_exc_adel;
  logic          r_exc_ades;
  logic          r_pend_adel;
  logic          r_pend_ades;

  logic          w_accept;
  logic          w_misaligned;
  logic          w_out_of_range;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_cur_word;
  logic [3:0]    w_be;
  logic [31:0]   w_lanes;
  logic [31:0]   w_merged;
  logic [31:0]   w_shift;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;

  assign rdata    = r_rdata;
  assign ready    = r_ready;
  assign busy     = r_busy;
  assign exc_adel = r_exc_adel;
  assign exc_ades = r_exc_ades;

  // Request qualification and address checks
  assign w_accept       = req && (r_state != S_WAIT);
  assign w_misaligned   = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
  assign w_out_of_range = {1'b0, addr} >= BYTE_LIMIT;
  assign w_err          = w_misaligned || w_out_of_range;
  assign w_idx          = addr[AW+1:2];
  assign w_cur_word     = r_mem[w_idx];

  // Store lane enables and right-aligned data replicated onto every lane
  always_comb begin
    w_be    = 4'b0000;
    w_lanes = wdata;
    case (size)
      2'b00: begin
        w_be[addr[1:0]] = 1'b1;
        w_lanes         = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_lanes = {2{wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_lanes = wdata;
      end
    endcase
  end

  always_comb begin
    w_merged = w_cur_word;
    for (int i = 0; i < 4; i++) begin
      if (w_be[i]) w_merged[8*i +: 8] = w_lanes[8*i +: 8];
    end
  end

  // Load lane select and extension
  assign w_shift = w_cur_word >> {addr[1:0], 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = addr[1] ? w_cur_word[31:16] : w_cur_word[15:0];

  always_comb begin
    w_load = w_cur_word;
    case (size)
      2'b00:   w_load = sign_ext ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
      2'b01:   w_load = sign_ext ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
      default: w_load = w_cur_word;
    endcase
  end

  // Handshake FSM: next state and wait counter
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_WAIT;
            w_cnt_next   = WAIT_LOAD;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) w_next_state = S_DONE;
        else             w_cnt_next   = r_cnt - CW'(1);
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_exc_adel  <= 1'b0;
      r_exc_ades  <= 1'b0;
      r_pend_adel <= 1'b0;
      r_pend_ades <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      r_ready <= (w_next_state == S_DONE);
      r_busy  <= (w_next_state == S_WAIT);
      if (w_accept) begin
        r_pend_adel <= w_err && !we;
        r_pend_ades <= w_err && we;
      end
      if (w_accept && !w_err && !we) r_rdata <= w_load;
      // Zero-wait accepts reach DONE directly, so flags come from the live check
      if (w_next_state == S_DONE) begin
        r_exc_adel <= w_accept ? (w_err && !we) : r_pend_adel;
        r_exc_ades <= w_accept ? (w_err && we)  : r_pend_ades;
      end else begin
        r_exc_adel <= 1'b0;
        r_exc_ades <= 1'b0;
      end
    end
  end

  // Storage array: cleared on reset, merged word committed on the accept edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) r_mem[AW'(i)] <= '0;
    end else if (w_accept && !w_err && we) begin
      r_mem[w_idx] <= w_merged;
      $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, w_merged);
    end
  end

endmodule

// File: tb/tb_dm_bus.sv
// Bench for dm_bus: a zero-wait and a three-wait instance, table vectors, randomized
// accesses against a byte-array reference model, and handshake/reset corner sequences.
module tb_dm_bus;

  localparam int unsigned NBYTES = 12288;

  logic        clk;
  logic        reset;
  logic [31:0] pc_i;
  logic        req0, req3;
  logic        we_i;
  logic [1:0]  size_i;
  logic        sign_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata0, rdata3;
  logic        ready0, ready3, busy0, busy3;
  logic        adel0, adel3, ades0, ades3;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mm  [2][NBYTES];
  logic [31:0] mrd [2];

  dm_bus #(.DEPTH_WORDS(3072), .WAIT_CYCLES(0), .AW(12)) dut0 (
    .clk(clk), .reset(reset), .pc(pc_i), .req(req0), .we(we_i), .size(size_i),
    .sign_ext(sign_i), .addr(addr_i), .wdata(wdata_i), .rdata(rdata0),
    .ready(ready0), .busy(busy0), .exc_adel(adel0), .exc_ades(ades0));

  dm_bus #(.DEPTH_WORDS(3072), .WAIT_CYCLES(3), .AW(12)) dut3 (
    .clk(clk), .reset(reset), .pc(pc_i), .req(req3), .we(we_i), .size(size_i),
    .sign_ext(sign_i), .addr(addr_i), .wdata(wdata_i), .rdata(rdata3),
    .ready(ready3), .busy(busy3), .exc_adel(adel3), .exc_ades(ades3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] o_rd(input int s);
    return (s == 0) ? rdata0 : rdata3;
  endfunction
  function automatic logic [3:0] o_flags(input int s);
    // {ready, busy, adel, ades}
    return (s == 0) ? {ready0, busy0, adel0, ades0} : {ready3, busy3, adel3, ades3};
  endfunction

  // Reference model: plain byte array, little-endian gather/scatter
  task automatic model_access(input int s, input logic w, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] rd, output logic adel, output logic ades);
    int nb;
    logic [63:0] v;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    adel = 1'b0;
    ades = 1'b0;
    if (((a & 32'(nb - 1)) != 0) || (a >= 32'(NBYTES))) begin
      adel = !w;
      ades = w;
    end else if (w) begin
      for (int i = 0; i < nb; i++) mm[s][int'(a) + i] = d[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v = v | (64'(mm[s][int'(a) + i]) << (8 * i));
      if (sx && nb < 4 && v[8*nb - 1]) v = v | (~64'd0 << (8 * nb));
      mrd[s] = v[31:0];
    end
    rd = mrd[s];
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < int'(NBYTES); i++) mm[s][i] = 8'h00;
      mrd[s] = '0;
    end
  endtask

  // One handshake; starts and ends #1 after a posedge, checks timing along the way
  task automatic run_access(input int s, input logic w, input logic [1:0] sz, input logic sx,
                            input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic adel, output logic ades);
    int wc;
    logic [3:0] f;
    wc = (s == 0) ? 0 : 3;
    we_i = w; size_i = sz; sign_i = sx; addr_i = a; wdata_i = d; pc_i = $urandom;
    if (s == 0) req0 = 1'b1; else req3 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0; req3 = 1'b0;
    for (int k = 0; k < wc; k++) begin
      f = o_flags(s);
      chk("busy_in_wait", 32'(f[2]), 32'd1);
      chk("ready_early", 32'(f[3]), 32'd0);
      @(posedge clk); #1;
    end
    f = o_flags(s);
    chk("ready_pulse", 32'(f[3]), 32'd1);
    chk("busy_in_done", 32'(f[2]), 32'd0);
    rd = o_rd(s); adel = f[1]; ades = f[0];
    @(posedge clk); #1;
    f = o_flags(s);
    chk("after_done_clear", 32'(f), 32'd0);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_adel;
    logic        exp_ades;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] er, input logic el, input logic es);
    vec_t v;
    v.w = w; v.sz = sz; v.sx = sx; v.a = a; v.d = d;
    v.exp_rd = er; v.exp_adel = el; v.exp_ades = es;
    return v;
  endfunction

  initial begin
    vec_t        tbl[$];
    logic [31:0] rd, mr;
    logic        adel, ades, madel, mades;
    logic        w, sx;
    logic [1:0]  sz;
    logic [31:0] a, d;
    int          r, cnt;

    tbl.push_back(mk(1, 2'b10, 0, 32'h10,       32'h12345678, 32'h00000000, 0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h10,       32'h0,        32'h12345678, 0, 0));
    tbl.push_back(mk(1, 2'b00, 0, 32'h11,       32'hFFFFFFAB, 32'h12345678, 0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h10,       32'h0,        32'h1234AB78, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 32'h11,       32'h0,        32'hFFFFFFAB, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 32'h11,       32'h0,        32'h000000AB, 0, 0));
    tbl.push_back(mk(0, 2'b01, 1, 32'h12,       32'h0,        32'h00001234, 0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h2,        32'h0,        32'h00001234, 1, 0));
    tbl.push_back(mk(1, 2'b01, 0, 32'h5,        32'hBEEF,     32'h00001234, 0, 1));
    tbl.push_back(mk(0, 2'b10, 0, 32'h4,        32'h0,        32'h00000000, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 32'h3000,     32'h55AA55AA, 32'h00000000, 0, 1));
    tbl.push_back(mk(0, 2'b10, 0, 32'h3000,     32'h0,        32'h00000000, 1, 0));
    tbl.push_back(mk(1, 2'b01, 0, 32'h12,       32'h00008001, 32'h00000000, 0, 0));
    tbl.push_back(mk(0, 2'b01, 1, 32'h12,       32'h0,        32'hFFFF8001, 0, 0));
    tbl.push_back(mk(0, 2'b01, 0, 32'h12,       32'h0,        32'h00008001, 0, 0));
    tbl.push_back(mk(0, 2'b11, 1, 32'h10,       32'h0,        32'h8001AB78, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 32'h13,       32'h0,        32'hFFFFFF80, 0, 0));
    tbl.push_back(mk(0, 2'b01, 0, 32'h11,       32'h0,        32'hFFFFFF80, 1, 0));
    tbl.push_back(mk(1, 2'b10, 0, 32'h2FFC,     32'hCAFEBABE, 32'hFFFFFF80, 0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h2FFC,     32'h0,        32'hCAFEBABE, 0, 0));
    tbl.push_back(mk(0, 2'b01, 0, 32'h2FFE,     32'h0,        32'h0000CAFE, 0, 0));
    tbl.push_back(mk(1, 2'b00, 0, 32'h3000,     32'h11,       32'h0000CAFE, 0, 1));
    tbl.push_back(mk(0, 2'b10, 0, 32'hFFFFFFFC, 32'h0,        32'h0000CAFE, 1, 0));

    reset = 1'b1; req0 = 1'b0; req3 = 1'b0; pc_i = '0; we_i = 1'b0;
    size_i = 2'b10; sign_i = 1'b0; addr_i = '0; wdata_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_rdata0", rdata0, 32'd0);
    chk("reset_rdata3", rdata3, 32'd0);
    chk("reset_flags0", 32'(o_flags(0)), 32'd0);
    chk("reset_flags3", 32'(o_flags(1)), 32'd0);

    // Directed table on the zero-wait instance
    foreach (tbl[i]) begin
      run_access(0, tbl[i].w, tbl[i].sz, tbl[i].sx, tbl[i].a, tbl[i].d, rd, adel, ades);
      model_access(0, tbl[i].w, tbl[i].sz, tbl[i].sx, tbl[i].a, tbl[i].d, mr, madel, mades);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_adel", i), 32'(adel), 32'(tbl[i].exp_adel));
      chk($sformatf("tbl%0d_ades", i), 32'(ades), 32'(tbl[i].exp_ades));
    end

    // Randomized accesses against the model on both instances
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < ((s == 0) ? 300 : 120); n++) begin
        r = $urandom_range(0, 9);
        if (r < 7)      a = 32'($urandom_range(0, 63));
        else if (r < 9) a = 32'(NBYTES - 8 + $urandom_range(0, 15));
        else            a = $urandom;
        w  = 1'($urandom_range(0, 1));
        sz = 2'($urandom_range(0, 3));
        sx = 1'($urandom_range(0, 1));
        d  = $urandom;
        run_access(s, w, sz, sx, a, d, rd, adel, ades);
        model_access(s, w, sz, sx, a, d, mr, madel, mades);
        chk($sformatf("rnd%0d_%0d_rdata", s, n), rd, mr);
        chk($sformatf("rnd%0d_%0d_exc", s, n), 32'({adel, ades}), 32'({madel, mades}));
      end
    end

    // Requests while busy are ignored
    we_i = 1'b1; size_i = 2'b10; addr_i = 32'h30; wdata_i = 32'h0BADF00D; req3 = 1'b1;
    @(posedge clk); #1;
    model_access(1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0BADF00D, mr, madel, mades);
    addr_i = 32'h34; wdata_i = 32'hDEADBEEF;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) req3 = 1'b0;
      @(posedge clk); #1;
      if (ready3) cnt++;
    end
    chk("busy_req_single_ready", 32'(cnt), 32'd1);
    run_access(1, 1'b0, 2'b10, 1'b0, 32'h34, 32'h0, rd, adel, ades);
    model_access(1, 1'b0, 2'b10, 1'b0, 32'h34, 32'h0, mr, madel, mades);
    chk("busy_req_no_store", rd, mr);
    run_access(1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, adel, ades);
    chk("busy_first_store", rd, 32'h0BADF00D);
    model_access(1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, mr, madel, mades);

    // Back-to-back loads with req held through DONE
    run_access(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111, rd, adel, ades);
    run_access(1, 1'b1, 2'b10, 1'b0, 32'h24, 32'h22222222, rd, adel, ades);
    model_access(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111, mr, madel, mades);
    model_access(1, 1'b1, 2'b10, 1'b0, 32'h24, 32'h22222222, mr, madel, mades);
    we_i = 1'b0; addr_i = 32'h20; req3 = 1'b1;
    @(posedge clk); #1;
    addr_i = 32'h24;
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_first_ready", 32'(ready3), 32'd1);
    chk("b2b_first_rdata", rdata3, 32'h11111111);
    @(posedge clk); #1;
    req3 = 1'b0;
    chk("b2b_no_gap_busy", 32'(busy3), 32'd1);
    chk("b2b_no_gap_ready", 32'(ready3), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_second_ready", 32'(ready3), 32'd1);
    chk("b2b_second_rdata", rdata3, 32'h22222222);
    model_access(1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, mr, madel, mades);
    @(posedge clk); #1;

    // Reset during WAIT aborts the access and clears memory
    we_i = 1'b1; addr_i = 32'h40; wdata_i = 32'h55555555; req3 = 1'b1;
    @(posedge clk); #1;
    req3 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("rst_wait_rdata", rdata3, 32'd0);
    chk("rst_wait_flags", 32'(o_flags(1)), 32'd0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (ready3) cnt++;
    end
    chk("rst_wait_no_ready", 32'(cnt), 32'd0);
    run_access(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, adel, ades);
    chk("rst_wait_word_cleared", rd, 32'd0);
    run_access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, adel, ades);
    chk("rst_dm0_word_cleared", rd, 32'd0);

    // Request on the reset edge is dropped
    we_i = 1'b1; addr_i = 32'h44; wdata_i = 32'h77777777; req3 = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    req3 = 1'b0; reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (ready3 || busy3) cnt++;
    end
    chk("rst_accept_dropped", 32'(cnt), 32'd0);
    run_access(1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0, rd, adel, ades);
    chk("rst_accept_no_store", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
